// File: rtl/spin_result.sv
// spin_result -- captures where the roulette wheel stops, flags a win against
// the player's target, blinks the LED ring while the result is held and keeps
// a saturating win score.
//
// Configuration macro: SPIN_RESULT_SCORE_EN
//   defined   -> 4-bit saturating win counter drives score_o
//   undefined -> score_o is tied to 0 and no score register exists
//
// Parameters:
//   BLINK_TICKS     tick_i pulses per LED blink phase (default 2000)
//
// Ports:
//   clk_i           system clock
//   rst_i           asynchronous, active-high reset
//   tick_i          single-cycle time-base strobe
//   running_i       wheel-running flag
//   pos_i[2:0]      current wheel position
//   target_i[2:0]   player-selected target position
//   led_o[7:0]      LED ring, bit n = position n
//   result_valid_o  a stopped-wheel result is held
//   result_pos_o    captured stop position
//   win_o           held result equals the target sampled at stop
//   score_o[3:0]    saturating count of wins since reset
module spin_result #(
    parameter int unsigned BLINK_TICKS = 2000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       running_i,
    input  logic [2:0] pos_i,
    input  logic [2:0] target_i,
    output logic [7:0] led_o,
    output logic       result_valid_o,
    output logic [2:0] result_pos_o,
    output logic       win_o,
    output logic [3:0] score_o
);

    localparam int unsigned CNT_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SPIN,
        SHOW
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       led_d;
    logic             valid_d;
    logic [2:0]       respos_d;
    logic             win_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (running_i)  state_d = SPIN;
            SPIN:    if (!running_i) state_d = SHOW;
            SHOW:    if (running_i)  state_d = SPIN;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs. led_d is derived
    // from the next state and next result/phase so every output changes on
    // the same edge as the transition that causes it.
    always_comb begin
        valid_d  = result_valid_o;
        respos_d = result_pos_o;
        win_d    = win_o;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                win_d   = 1'b0;
                cnt_d   = '0;
                phase_d = 1'b0;
            end
            SPIN: begin
                // Stop edge: capture result; a coincident tick is not counted.
                if (!running_i) begin
                    respos_d = pos_i;
                    win_d    = (pos_i == target_i);
                    valid_d  = 1'b1;
                    cnt_d    = '0;
                    phase_d  = 1'b0;
                end
            end
            SHOW: begin
                if (running_i) begin
                    valid_d = 1'b0;
                    win_d   = 1'b0;
                    cnt_d   = '0;
                    phase_d = 1'b0;
                end else if (tick_i) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        phase_d = ~phase_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                win_d   = 1'b0;
                cnt_d   = '0;
                phase_d = 1'b0;
            end
        endcase

        led_d = '0;
        case (state_d)
            SPIN: led_d = 8'h01 << pos_i;
            SHOW: begin
                if (!phase_d) begin
                    led_d = win_d ? 8'hFF : (8'h01 << respos_d);
                end
            end
            default: led_d = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            led_o          <= '0;
            result_valid_o <= 1'b0;
            result_pos_o   <= '0;
            win_o          <= 1'b0;
            cnt_q          <= '0;
            phase_q        <= 1'b0;
        end else begin
            led_o          <= led_d;
            result_valid_o <= valid_d;
            result_pos_o   <= respos_d;
            win_o          <= win_d;
            cnt_q          <= cnt_d;
            phase_q        <= phase_d;
        end
    end

`ifdef SPIN_RESULT_SCORE_EN
    logic [3:0] score_q;
    logic       win_evt;

    assign win_evt = (state_q == SPIN) && !running_i && (pos_i == target_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            score_q <= '0;
        end else if (win_evt && (score_q != 4'hF)) begin
            score_q <= score_q + 4'd1;
        end
    end

    assign score_o = score_q;
`else
    assign score_o = '0;
`endif

endmodule

// File: tb/tb_spin_result.sv
// Directed self-checking bench for spin_result (default BLINK_TICKS = 2000).
// Expected score depends on whether SPIN_RESULT_SCORE_EN is defined.
module tb_spin_result;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       tick_i;
    logic       running_i;
    logic [2:0] pos_i;
    logic [2:0] target_i;
    logic [7:0] led_o;
    logic       result_valid_o;
    logic [2:0] result_pos_o;
    logic       win_o;
    logic [3:0] score_o;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned exp_score = 0;

    spin_result #(.BLINK_TICKS(2000)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .tick_i         (tick_i),
        .running_i      (running_i),
        .pos_i          (pos_i),
        .target_i       (target_i),
        .led_o          (led_o),
        .result_valid_o (result_valid_o),
        .result_pos_o   (result_pos_o),
        .win_o          (win_o),
        .score_o        (score_o)
    );

    always #10 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [7:0] led, input logic valid,
                             input logic [2:0] rpos, input logic win, input logic [3:0] score);
        check({tag, ".led"},   32'(led_o),          32'(led));
        check({tag, ".valid"}, 32'(result_valid_o), 32'(valid));
        check({tag, ".rpos"},  32'(result_pos_o),   32'(rpos));
        check({tag, ".win"},   32'(win_o),          32'(win));
        check({tag, ".score"}, 32'(score_o),        32'(score));
    endtask

    function automatic logic [3:0] score_exp();
`ifdef SPIN_RESULT_SCORE_EN
        return 4'(exp_score);
`else
        return 4'd0;
`endif
    endfunction

    initial begin
        // Reset with random inputs
        rst_i = 1'b1; tick_i = 1'b0; running_i = 1'b0; pos_i = '0; target_i = '0;
        #3;
        check_all("rst_async", 8'h00, 1'b0, 3'd0, 1'b0, 4'd0);
        for (int i = 0; i < 4; i++) begin
            tick_i = 1'($urandom); running_i = 1'($urandom);
            pos_i = 3'($urandom); target_i = 3'($urandom);
            step();
            check_all("rst_rand", 8'h00, 1'b0, 3'd0, 1'b0, 4'd0);
        end
        running_i = 1'b0; tick_i = 1'b0;
        rst_i = 1'b0;
        step(); step();
        check_all("idle", 8'h00, 1'b0, 3'd0, 1'b0, 4'd0);

        // Spin tracking, one clock of latency
        running_i = 1'b1; pos_i = 3'd0;
        step();
        check("spin_led0", 32'(led_o), 32'h01);
        for (int p = 1; p < 8; p++) begin
            pos_i = 3'(p);
            #1;
            check("spin_latency", 32'(led_o), 32'(8'h01 << (p - 1)));
            step();
            check("spin_led", 32'(led_o), 32'(8'h01 << p));
        end

        // Loss: stop at 3 with target 5; coincident tick must not be counted
        pos_i = 3'd3; target_i = 3'd5; running_i = 1'b0; tick_i = 1'b1;
        step();
        check_all("loss_stop", 8'h08, 1'b1, 3'd3, 1'b0, 4'd0);
        for (int i = 0; i < 1999; i++) step();
        check("loss_last_on", 32'(led_o), 32'h08);
        step();
        check("loss_off", 32'(led_o), 32'h00);
        target_i = 3'd3; pos_i = 3'd7;
        for (int i = 0; i < 1999; i++) step();
        check_all("loss_hold", 8'h00, 1'b1, 3'd3, 1'b0, 4'd0);
        step();
        check("loss_on_again", 32'(led_o), 32'h08);
        tick_i = 1'b0;

        // Restart from SHOW
        running_i = 1'b1; pos_i = 3'd2;
        step();
        check_all("restart", 8'h04, 1'b0, 3'd3, 1'b0, 4'd0);

        // Win and saturation: 17 stops at pos = target = 6
        for (int k = 0; k < 17; k++) begin
            running_i = 1'b1; pos_i = 3'd1;
            step();
            check("win_spin_led", 32'(led_o), 32'h02);
            pos_i = 3'd6; target_i = 3'd6; running_i = 1'b0;
            step();
            if (exp_score < 15) exp_score++;
            check_all("win_stop", 8'hFF, 1'b1, 3'd6, 1'b1, score_exp());
            if (k == 0) begin
                tick_i = 1'b1;
                for (int i = 0; i < 2000; i++) step();
                check("win_off", 32'(led_o), 32'h00);
                target_i = 3'd0;
                for (int i = 0; i < 2000; i++) step();
                check_all("win_on", 8'hFF, 1'b1, 3'd6, 1'b1, score_exp());
                tick_i = 1'b0;
            end
        end

        // Mid-SHOW asynchronous reset
        rst_i = 1'b1;
        #2;
        check_all("mid_rst", 8'h00, 1'b0, 3'd0, 1'b0, 4'd0);
        step();
        rst_i = 1'b0; running_i = 1'b0;
        step();
        check_all("post_rst_idle", 8'h00, 1'b0, 3'd0, 1'b0, 4'd0);
        running_i = 1'b1; pos_i = 3'd5;
        step();
        check_all("post_rst_spin", 8'h20, 1'b0, 3'd0, 1'b0, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spin_result.md
SPIN_RESULT -- requirements
Module: spin_result

Interface
REQ-001 Parameter: BLINK_TICKS, default 2000, number of tick_i pulses per LED blink phase (2000 x 50 us = 100 ms at 20 kHz).
REQ-002 clk_i  input  1  system clock, 50 MHz.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 tick_i  input  1  single-cycle 20 kHz time-base strobe.
REQ-005 running_i  input  1  wheel-running flag from the wheel block.
REQ-006 pos_i  input  3  current wheel position, 0..7.
REQ-007 target_i  input  3  player-selected target position, 0..7.
REQ-008 led_o  output  8  LED ring drive, bit n = position n.
REQ-009 result_valid_o  output  1  high while a stopped-wheel result is held.
REQ-010 result_pos_o  output  3  captured stop position.
REQ-011 win_o  output  1  high while the held result equals the target.
REQ-012 score_o  output  4  count of wins since reset, saturating.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, SPIN and SHOW.
REQ-014 IDLE SHALL move to SPIN on the first clock edge at which running_i=1; led_o=0 in IDLE.
REQ-015 In SPIN, led_o SHALL equal one-hot(pos_i) registered, i.e. 1 clock of latency.
REQ-016 SPIN SHALL move to SHOW on the first clock edge at which running_i=0; on that edge result_pos_o<=pos_i, win_o<=(pos_i==target_i) and result_valid_o<=1.
REQ-017 target_i SHALL be sampled only on the SPIN->SHOW edge; later target_i changes SHALL NOT alter win_o.
REQ-018 On the SPIN->SHOW edge with a win, score_o SHALL increment by 1, saturating at 15 (no wrap).
REQ-019 In SHOW, a blink counter SHALL count tick_i pulses from 0 to BLINK_TICKS-1, then wrap to 0 and toggle a blink phase bit; the counter and phase SHALL be 0 (LED on) on SHOW entry.
REQ-020 In SHOW, led_o SHALL be one-hot(result_pos_o) when phase=0 and 0 when phase=1; a win SHALL instead show all 8 LEDs (8'hFF) when phase=0.
REQ-021 SHOW SHALL move to SPIN on the first clock edge at which running_i=1; on that edge result_valid_o<=0, win_o<=0 and the blink counter/phase are cleared; result_pos_o and score_o SHALL hold.
REQ-022 pos_i changes during SHOW SHALL NOT affect any output.
REQ-023 tick_i SHALL be ignored in IDLE and SPIN.
REQ-024 A tick_i coincident with the SPIN->SHOW edge SHALL NOT be counted.
REQ-025 All outputs SHALL be driven from registers.

Reset
REQ-026 While rst_i=1, the block SHALL hold state=IDLE, led_o=0, result_valid_o=0, result_pos_o=0, win_o=0, score_o=0, blink counter=0 and phase=0, asynchronously and regardless of clk_i.
REQ-027 Reset asserted in any state, including mid-SHOW, SHALL discard the held result and score; after release the FSM SHALL re-enter via IDLE.

Configuration
REQ-028 With macro SPIN_RESULT_SCORE_EN defined, the score counter of REQ-018 SHALL be compiled in.
REQ-029 With SPIN_RESULT_SCORE_EN undefined, score_o SHALL be constant 0, no score register SHALL exist, and all other behaviour SHALL be unchanged.

Verification
REQ-030 Reset: with rst_i=1 and random inputs, all outputs SHALL read 0; state SHALL be IDLE after release with running_i=0.
REQ-031 Spin tracking: running_i=1 and pos_i stepping 0..7 -> led_o = 8'h01..8'h80, each 1 clock after pos_i.
REQ-032 Loss: stop at pos_i=3 with target_i=5 -> result_valid_o=1, result_pos_o=3, win_o=0, score unchanged; led_o alternates 8'h08/8'h00 every 2000 ticks.
REQ-033 Win and saturation: 17 stops at pos_i=target_i=6 -> win_o=1 each time, led_o alternates 8'hFF/8'h00, score_o = 1..15, then stays 15.
REQ-034 Restart and mid-SHOW reset: running_i 0->1 in SHOW -> result_valid_o=0, win_o=0, led_o tracks pos_i; rst_i pulse in SHOW -> all outputs 0, score_o=0.
REQ-035 Macro build: repeat REQ-033 without SPIN_RESULT_SCORE_EN -> identical win_o/led_o behaviour, score_o=0 throughout.
